// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: Funct3 size encodings,
// the access-size enum and default geometry constants.
package dmem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int CNT_W_DEF  = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

    // Maps Funct3 to an access size; unsigned variants only exist for loads,
    // so they decode to SZ_NONE on the store path.
    function automatic size_e f3_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_NONE;
        case (f3)
            F3_B:    sz = SZ_BYTE;
            F3_H:    sz = SZ_HALF;
            F3_W:    sz = SZ_WORD;
            F3_BU:   sz = is_store ? SZ_NONE : SZ_BYTE;
            F3_HU:   sz = is_store ? SZ_NONE : SZ_HALF;
            default: sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational legality check for one access direction: decides whether the
// size/alignment combination is allowed and which byte lanes of the word it
// touches. Lane enables are all zero for an illegal access.
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] funct3,
    input  logic       is_store,
    output logic       legal,
    output logic [3:0] lane_en
);

    size_e size;
    assign size = f3_size(funct3, is_store);

    // Size decode, alignment rule and lane-enable generation
    always_comb begin
        legal   = 1'b0;
        lane_en = 4'b0000;
        case (size)
            SZ_BYTE: begin
                legal   = 1'b1;
                lane_en = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                legal = ~addr_lo[0];
                if (legal) lane_en = 4'b0011 << addr_lo;
            end
            SZ_WORD: begin
                legal = (addr_lo == 2'b00);
                if (legal) lane_en = 4'b1111;
            end
            default: begin
                legal   = 1'b0;
                lane_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core data-memory interface: 512-byte store held as
// 32-bit words, zero-latency loads with sign/zero extension, edge-triggered
// stores, sticky misalignment/illegal-size error and access counters.
// Optional write-trace outputs are built when DMEM_TRACE_EN is defined.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
`ifdef DMEM_TRACE_EN
    ,
    output logic              mem_wr_sig,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
`endif
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem_q [WORDS];

    logic [ADDR_W-3:0] word_idx;
    logic [4:0]        lane_shift;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] wr_sh;
    logic [DATA_W-1:0] wr_word_d;
    logic              rd_legal, wr_legal;
    logic [3:0]        rd_lane, wr_lane;
    logic              rd_fire, wr_fire, err_fire;

    logic              misalign_err_q, misalign_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;

    assign word_idx   = addr[ADDR_W-1:2];
    assign lane_shift = {addr[1:0], 3'b000};
    assign rd_word    = mem_q[word_idx];
    assign rd_sh      = rd_word >> lane_shift;
    assign wr_sh      = wr_data << lane_shift;

    dmem_align_check u_rd_check (
        .addr_lo  (addr[1:0]),
        .funct3   (funct3),
        .is_store (1'b0),
        .legal    (rd_legal),
        .lane_en  (rd_lane)
    );

    dmem_align_check u_wr_check (
        .addr_lo  (addr[1:0]),
        .funct3   (funct3),
        .is_store (1'b1),
        .legal    (wr_legal),
        .lane_en  (wr_lane)
    );

    assign rd_fire  = rd & rd_legal;
    assign wr_fire  = wr & wr_legal;
    assign err_fire = (rd & ~rd_legal) | (wr & ~wr_legal);

    // Merge the shifted store bytes into the current word, lane by lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word_d[8*gi +: 8] = wr_lane[gi] ? wr_sh[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    // Load path: extend the addressed byte/halfword; illegal or idle gives 0.
    // Reads the pre-store word, so a same-cycle store is not visible yet.
    always_comb begin
        rd_data = '0;
        if (rd_fire) begin
            case (funct3)
                F3_B:    rd_data = {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
                F3_BU:   rd_data = {{(DATA_W-8){1'b0}}, rd_sh[7:0]};
                F3_H:    rd_data = {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
                F3_HU:   rd_data = {{(DATA_W-16){1'b0}}, rd_sh[15:0]};
                default: rd_data = rd_word;
            endcase
        end
    end

    // Store array: cleared on reset, one merged word written per legal store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (wr_fire) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    // Next-state for sticky error, first-error address and access counters
    always_comb begin
        misalign_err_d = misalign_err_q | err_fire;
        err_addr_d     = err_addr_q;
        if (err_fire && !misalign_err_q) err_addr_d = addr;
        wr_count_d = wr_count_q + CNT_W'(wr_fire);
        rd_count_d = rd_count_q + CNT_W'(rd_fire);
    end

    // Status and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
            wr_count_q     <= '0;
            rd_count_q     <= '0;
        end else begin
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
            wr_count_q     <= wr_count_d;
            rd_count_q     <= rd_count_d;
        end
    end

    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;
    assign wr_count     = wr_count_q;
    assign rd_count     = rd_count_q;

`ifdef DMEM_TRACE_EN
    logic              mem_wr_sig_q, mem_wr_sig_d;
    logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;

    // Trace next-state: one-cycle pulse carrying the store address and merged word
    always_comb begin
        mem_wr_sig_d  = wr_fire;
        mem_wr_addr_d = wr_fire ? addr      : mem_wr_addr_q;
        mem_wr_data_d = wr_fire ? wr_word_d : mem_wr_data_q;
    end

    // Trace registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_sig_q  <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            mem_wr_sig_q  <= mem_wr_sig_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign mem_wr_sig  = mem_wr_sig_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
`endif

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: accepts the `wr`/`rd`/`addr`/`wr_data` requests driven by the datapath MEM stage and returns `rd_data`.
- Byte-addressable 512-byte store, organised as 128 x 32-bit words.
- Supports byte, halfword and word sizes, signed or unsigned, selected by the instruction's Funct3.
- Adds misalignment/illegal-size detection and access counters for verification and debug.

Parameters:
- DATA_W, 32, data width of `wr_data`/`rd_data`; only 32 is supported.
- ADDR_W, 9, byte-address width; depth = 2**ADDR_W bytes.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  store request this cycle.
- rd  in  1  load request this cycle.
- addr  in  ADDR_W  byte address.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wr_data  in  DATA_W  store data; low bytes are used for B/H.
- rd_data  out  DATA_W  load data, extended to DATA_W.
- misalign_err  out  1  sticky error flag.
- err_addr  out  ADDR_W  address of the first erroneous access.
- wr_count  out  CNT_W  number of accepted stores.
- rd_count  out  CNT_W  number of accepted loads.

Behaviour:
- Reset (synchronous, active-high): all memory bytes = 0, `misalign_err` = 0, `err_addr` = 0, `wr_count` = 0, `rd_count` = 0. `rd_data` follows the combinational rule below, so it reads 0 after reset.
- Reset mid-operation: reset has priority over any `wr`/`rd` in the same cycle. That cycle's store is discarded and its counters are not incremented.
- Loads are combinational (zero latency). `rd_data` is valid in the same cycle `rd` = 1, to fit the single-cycle MEM stage.
- `rd` = 0 -> `rd_data` = 0.
- Load extension:
  - B sign-extends `mem[addr]`; BU zero-extends it.
  - H sign-extends the little-endian halfword {`mem[addr+1]`, `mem[addr]`}; HU zero-extends it.
  - W returns {`mem[addr+3]`, …, `mem[addr]`}.
- Stores write on the rising edge when `wr` = 1. B writes byte 0 of `wr_data`, H writes bytes 1:0, W writes all four bytes, little-endian.
- Alignment rules:
  - H/HU require `addr[0]` = 0.
  - W requires `addr[1:0]` = 0.
  - B/BU are always aligned.
- Legal sizes: stores accept only B, H, W. Loads accept B, H, W, BU, HU. Any other Funct3 is illegal for that direction.
- Error access (misaligned or illegal size, with `rd` or `wr` asserted):
  - Memory is not modified.
  - `rd_data` = 0.
  - The counter for that direction does not increment.
  - `misalign_err` is set on the next edge and held until reset.
  - `err_addr` captures `addr` only if `misalign_err` was 0 beforehand, i.e. the first error only.
- Simultaneous `rd` and `wr`:
  - Read-before-write: `rd_data` shows the pre-store contents.
  - Both are checked independently against their own legality rules using the shared `addr`/`funct3`.
  - Each legal direction increments its own counter.
- Counters increment by 1 per legal accepted access and wrap from 2**CNT_W-1 to 0 silently.
- Address wrap: none is needed. Aligned accesses never cross byte 511, and misaligned ones are rejected.

Optional Feature:
- Macro: `DMEM_TRACE_EN`.
- When defined, three extra outputs are added: `mem_wr_sig` (1 bit), `mem_wr_addr` (ADDR_W bits) and `mem_wr_data` (DATA_W bits).
  - They are registered one cycle after each accepted store.
  - `mem_wr_sig` = 1 for exactly one cycle.
  - `mem_wr_addr` is the store's byte address.
  - `mem_wr_data` is the full resulting aligned word containing the store.
  - All three reset to 0.
  - An error store produces no pulse.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package `dmem_pkg`:
  - Funct3 size encodings as named constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - An enum typedef for access size.
  - Default ADDR_W/CNT_W constants.
- One natural sub-module, `dmem_align_check`: combinational, takes `addr[1:0]`, `funct3` and `is_store`, and produces `legal` and the per-byte lane enables. The top instantiates it twice, once for the store path and once for the load path.

Test Plan:
- Reset, then `rd` W at addr 0 -> `rd_data` = 0x00000000; all counters 0; `misalign_err` = 0.
- SW 0x8000_80F1 at addr 8, then LB@8 -> 0xFFFFFFF1; LBU@8 -> 0x000000F1; LH@8 -> 0xFFFF80F1; LHU@10 -> 0x00008000; `wr_count` = 1, `rd_count` = 4.
- SB 0xAB@13 then LW@12 -> byte 1 replaced, other bytes unchanged: 0x0000AB00 when word 12 starts at 0.
- SW at addr 6 (misaligned) -> memory unchanged; `misalign_err` = 1; `err_addr` = 6; `wr_count` unchanged. A following LH@3 keeps `err_addr` = 6.
- Same cycle: `rd`+`wr` W@20, old content 0x11111111, `wr_data` 0x22222222 -> `rd_data` = 0x11111111 that cycle; next-cycle LW@20 -> 0x22222222; both counters +1.
- `reset` asserted in the same cycle as SW@0 = 0xDEADBEEF -> LW@0 afterwards returns 0; with `DMEM_TRACE_EN`, `mem_wr_sig` never pulses.
